// File: rtl/bsg_nonsynth_reset_monitor_pkg.sv
// Shared types for the reset monitor: FSM states and the 3-bit error codes.
package bsg_nonsynth_reset_monitor_pkg;

    typedef enum logic [1:0] {
        eWaitLo = 2'd0,
        eHigh   = 2'd1,
        eDone   = 2'd2,
        eError  = 2'd3
    } state_e;

    typedef enum logic [2:0] {
        eCodeNone    = 3'd0,
        eCodeShort   = 3'd1,
        eCodeLong    = 3'd2,
        eCodeExtra   = 3'd3,
        eCodeTimeout = 3'd4
    } err_code_e;

    // Human-readable name of an error code for the verdict banner.
    function automatic string code_name(err_code_e code);
        case (code)
            eCodeNone:    return "NONE";
            eCodeShort:   return "SHORT";
            eCodeLong:    return "LONG";
            eCodeExtra:   return "EXTRA";
            eCodeTimeout: return "TIMEOUT";
            default:      return "UNKNOWN";
        endcase
    endfunction

endpackage

// File: rtl/bsg_nonsynth_reset_monitor_if.sv
// Reset link between the asynchronous reset source and the synchronizer.
interface bsg_nonsynth_reset_monitor_if;
    logic async_reset;
    logic sync_reset;

    // Reset source side: drives the raw reset, may observe the synchronized copy.
    modport master (output async_reset, input sync_reset);
    // Synchronizer side: samples the raw reset, produces the synchronized copy.
    modport slave  (input async_reset, output sync_reset);
endinterface

// File: rtl/bsg_nonsynth_reset_monitor_sync.sv
// N-stage flop synchronizer with synchronous clear for the monitored reset.
module bsg_nonsynth_reset_monitor_sync #(
    parameter int stages_p = 2
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    bsg_nonsynth_reset_monitor_if.slave sync_if
);
    logic [stages_p-1:0] r_sync;

    // Shift the raw reset through the stages; clear all stages on monitor reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[stages_p-2:0], sync_if.async_reset};
        end
    end

    assign sync_if.sync_reset = r_sync[stages_p-1];
endmodule

// File: rtl/bsg_nonsynth_reset_monitor.sv
// Simulation-only monitor: synchronizes an async reset, measures each pulse
// in clk_i cycles, checks it against bounds and prints a verdict banner.
`ifndef BSG_INV_PARAM
`define BSG_INV_PARAM(param) param = 1
`endif
`ifndef BSG_ABSTRACT_MODULE
`define BSG_ABSTRACT_MODULE(fn)
`endif

module bsg_nonsynth_reset_monitor
    import bsg_nonsynth_reset_monitor_pkg::*;
#(
    parameter int sync_stages_p = 2,
    parameter int `BSG_INV_PARAM(min_hi_cycles_p),
    parameter int `BSG_INV_PARAM(max_hi_cycles_p),
    parameter int max_lo_cycles_p = 0,
    parameter int max_events_p    = 1,
    localparam int hi_w_lp = $clog2(max_hi_cycles_p + 2),
    localparam int ev_w_lp = $clog2(max_events_p + 1)
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               async_reset_i,
    output logic               sync_reset_o,
    output logic               done_o,
    output logic               error_o,
    output logic [2:0]         error_code_o,
    output logic [hi_w_lp-1:0] hi_cycles_o,
    output logic [ev_w_lp-1:0] event_count_o
);
    localparam int lo_w_lp = $clog2(max_lo_cycles_p + 2);
    // Bounds at counter width so every check is a plain unsigned compare.
    localparam logic [hi_w_lp-1:0] hi_min_lp = hi_w_lp'(min_hi_cycles_p);
    localparam logic [hi_w_lp-1:0] hi_max_lp = hi_w_lp'(max_hi_cycles_p);
    localparam logic [lo_w_lp-1:0] lo_max_lp = lo_w_lp'(max_lo_cycles_p);
    localparam logic [ev_w_lp-1:0] ev_max_lp = ev_w_lp'(max_events_p);
    localparam bit                 lo_en_lp  = (max_lo_cycles_p != 0);

    bsg_nonsynth_reset_monitor_if w_if ();

    logic w_sync, w_rise;
    logic r_prev;
    state_e r_state, r_state_d;
    err_code_e r_code;
    logic r_done, r_err;
    logic [lo_w_lp-1:0] r_lo_cnt;
    logic [hi_w_lp-1:0] r_hi_cnt;
    logic [ev_w_lp-1:0] r_ev_cnt;

    assign w_if.async_reset = async_reset_i;

    bsg_nonsynth_reset_monitor_sync #(.stages_p(sync_stages_p)) u_sync (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .sync_if (w_if)
    );

    assign w_sync = w_if.sync_reset;
    assign w_rise = w_sync & ~r_prev;

    // Previous synchronized value for edge detection.
    always_ff @(posedge clk_i) begin
        if (reset_i) r_prev <= 1'b0;
        else         r_prev <= w_sync;
    end

    // Pulse measurement FSM with registered verdict outputs.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state  <= eWaitLo;
            r_code   <= eCodeNone;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_lo_cnt <= '0;
            r_hi_cnt <= '0;
            r_ev_cnt <= '0;
        end else begin
            case (r_state)
                eWaitLo: begin
                    if (w_rise) begin
                        r_hi_cnt <= hi_w_lp'(1);
                        r_state  <= eHigh;
                    end else if (lo_en_lp && (r_ev_cnt == '0) && (r_lo_cnt == lo_max_lp)) begin
                        r_code  <= eCodeTimeout;
                        r_err   <= 1'b1;
                        r_state <= eError;
                    end else if (!w_sync && (r_lo_cnt != '1)) begin
                        r_lo_cnt <= r_lo_cnt + lo_w_lp'(1);
                    end
                end
                eHigh: begin
                    // A low sample is checked first, so a fall beats LONG.
                    if (!w_sync) begin
                        if (r_hi_cnt < hi_min_lp) begin
                            r_code  <= eCodeShort;
                            r_err   <= 1'b1;
                            r_state <= eError;
                        end else begin
                            r_ev_cnt <= r_ev_cnt + ev_w_lp'(1);
                            if ((r_ev_cnt + ev_w_lp'(1)) == ev_max_lp) begin
                                r_done  <= 1'b1;
                                r_state <= eDone;
                            end else begin
                                r_lo_cnt <= '0;
                                r_state  <= eWaitLo;
                            end
                        end
                    end else if (r_hi_cnt == hi_max_lp) begin
                        r_code  <= eCodeLong;
                        r_err   <= 1'b1;
                        r_state <= eError;
                    end else if (r_hi_cnt != '1) begin
                        r_hi_cnt <= r_hi_cnt + hi_w_lp'(1);
                    end
                end
                eDone: begin
                    if (w_rise) begin
                        r_code  <= eCodeExtra;
                        r_err   <= 1'b1;
                        r_done  <= 1'b0;
                        r_state <= eError;
                    end
                end
                default: begin
                    // eError holds everything until the monitor reset.
                end
            endcase
        end
    end

    // Print one verdict banner on each entry into eDone or eError.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state_d <= eWaitLo;
        end else begin
            r_state_d <= r_state;
            if (r_state == eDone && r_state_d != eDone)
                $display("[%0d] bsg_nonsynth_reset_monitor: PASS (%0d pulses)", $stime, r_ev_cnt);
            if (r_state == eError && r_state_d != eError)
                $display("[%0d] bsg_nonsynth_reset_monitor: ERROR code=%0d (%s)",
                         $stime, r_code, code_name(r_code));
        end
    end

    assign sync_reset_o  = w_sync;
    assign done_o        = r_done;
    assign error_o       = r_err;
    assign error_code_o  = r_code;
    assign hi_cycles_o   = r_hi_cnt;
    assign event_count_o = r_ev_cnt;
endmodule

`BSG_ABSTRACT_MODULE(bsg_nonsynth_reset_monitor)

// File: tb/tb_bsg_nonsynth_reset_monitor.sv
// Directed bench: two monitors (max_events 1 and 2) share one reset source.
module tb_bsg_nonsynth_reset_monitor;
    logic clk = 1'b0;
    logic reset = 1'b1;

    bsg_nonsynth_reset_monitor_if src_if ();

    logic       a_done, a_err;
    logic [2:0] a_code;
    logic [3:0] a_hi;
    logic [0:0] a_ev;
    logic       b_sync, b_done, b_err;
    logic [2:0] b_code;
    logic [3:0] b_hi;
    logic [1:0] b_ev;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    bsg_nonsynth_reset_monitor #(
        .sync_stages_p(2), .min_hi_cycles_p(4), .max_hi_cycles_p(8),
        .max_lo_cycles_p(16), .max_events_p(1)
    ) dut_a (
        .clk_i(clk), .reset_i(reset), .async_reset_i(src_if.async_reset),
        .sync_reset_o(src_if.sync_reset), .done_o(a_done), .error_o(a_err),
        .error_code_o(a_code), .hi_cycles_o(a_hi), .event_count_o(a_ev)
    );

    bsg_nonsynth_reset_monitor #(
        .sync_stages_p(2), .min_hi_cycles_p(4), .max_hi_cycles_p(8),
        .max_lo_cycles_p(16), .max_events_p(2)
    ) dut_b (
        .clk_i(clk), .reset_i(reset), .async_reset_i(src_if.async_reset),
        .sync_reset_o(b_sync), .done_o(b_done), .error_o(b_err),
        .error_code_o(b_code), .hi_cycles_o(b_hi), .event_count_o(b_ev)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_a(input string tag, input int s, input int d, input int e,
                           input int c, input int h, input int ev);
        chk({tag, ".A.sync"}, int'(src_if.sync_reset), s);
        chk({tag, ".A.done"}, int'(a_done), d);
        chk({tag, ".A.err"},  int'(a_err),  e);
        chk({tag, ".A.code"}, int'(a_code), c);
        chk({tag, ".A.hi"},   int'(a_hi),   h);
        chk({tag, ".A.ev"},   int'(a_ev),   ev);
        $display("vec %-12s A: sync=%0d done=%0d err=%0d code=%0d hi=%0d ev=%0d",
                 tag, src_if.sync_reset, a_done, a_err, a_code, a_hi, a_ev);
    endtask

    task automatic check_b(input string tag, input int s, input int d, input int e,
                           input int c, input int h, input int ev);
        chk({tag, ".B.sync"}, int'(b_sync), s);
        chk({tag, ".B.done"}, int'(b_done), d);
        chk({tag, ".B.err"},  int'(b_err),  e);
        chk({tag, ".B.code"}, int'(b_code), c);
        chk({tag, ".B.hi"},   int'(b_hi),   h);
        chk({tag, ".B.ev"},   int'(b_ev),   ev);
        $display("vec %-12s B: sync=%0d done=%0d err=%0d code=%0d hi=%0d ev=%0d",
                 tag, b_sync, b_done, b_err, b_code, b_hi, b_ev);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        steps(2);
        reset = 1'b0;
    endtask

    // High for n cycles; returns on the edge where the source drops low.
    task automatic pulse(input int n);
        src_if.async_reset = 1'b1;
        steps(n);
        src_if.async_reset = 1'b0;
    endtask

    initial begin
        src_if.async_reset = 1'b0;

        // Reset state
        do_reset();
        check_a("reset", 0, 0, 0, 0, 0, 0);
        check_b("reset", 0, 0, 0, 0, 0, 0);

        // Legal 6-cycle pulse; done one cycle after the synchronized fall
        steps(5);
        pulse(6);
        steps(2);
        check_a("legal_hi", 0, 0, 0, 0, 6, 0);
        step();
        check_a("legal_done", 0, 1, 0, 0, 6, 1);
        check_b("legal_done", 0, 0, 0, 0, 6, 1);

        // Second pulse: EXTRA for one-event monitor, done for two-event monitor
        steps(3);
        pulse(6);
        steps(3);
        check_a("extra", 0, 0, 1, 3, 6, 1);
        check_b("second_ok", 0, 1, 0, 0, 6, 2);

        // Short pulse, then first error code sticks through another pulse
        do_reset();
        check_a("reset2", 0, 0, 0, 0, 0, 0);
        steps(2);
        pulse(3);
        steps(2);
        check_a("short_pre", 0, 0, 0, 0, 3, 0);
        step();
        check_a("short", 0, 0, 1, 1, 3, 0);
        check_b("short", 0, 0, 1, 1, 3, 0);
        pulse(6);
        steps(3);
        check_a("sticky", 0, 0, 1, 1, 3, 0);

        // Minimum legal length
        do_reset();
        steps(2);
        pulse(4);
        steps(3);
        check_a("min_ok", 0, 1, 0, 0, 4, 1);
        check_b("min_ok", 0, 0, 0, 0, 4, 1);

        // Maximum legal length: the fall wins over LONG
        do_reset();
        steps(2);
        pulse(8);
        steps(2);
        check_a("max_pre", 0, 0, 0, 0, 8, 0);
        step();
        check_a("max_ok", 0, 1, 0, 0, 8, 1);
        check_b("max_ok", 0, 0, 0, 0, 8, 1);

        // Reset mid-pulse, then stuck high after release
        do_reset();
        steps(2);
        src_if.async_reset = 1'b1;
        steps(4);
        check_a("mid_pulse", 1, 0, 0, 0, 2, 0);
        reset = 1'b1;
        step();
        check_a("abort", 0, 0, 0, 0, 0, 0);
        check_b("abort", 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        step();
        check_a("rel_1", 0, 0, 0, 0, 0, 0);
        step();
        check_a("rel_2", 1, 0, 0, 0, 0, 0);
        step();
        check_a("rise", 1, 0, 0, 0, 1, 0);
        steps(7);
        check_a("stuck_pre", 1, 0, 0, 0, 8, 0);
        step();
        check_a("long", 1, 0, 1, 2, 8, 0);
        check_b("long", 1, 0, 1, 2, 8, 0);

        // No pulse: timeout the cycle after lo_cnt reaches 16
        src_if.async_reset = 1'b0;
        do_reset();
        steps(16);
        check_a("to_pre", 0, 0, 0, 0, 0, 0);
        step();
        check_a("timeout", 0, 0, 1, 4, 0, 0);
        check_b("timeout", 0, 0, 1, 4, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
